// File: rtl/vm8_seq_ctrl.sv
// 8x8 unsigned multiplier sequencing one 4x4 Vedic core over four steps.
// Optional VM8_ZERO_SKIP_EN: zero operands bypass the MUL steps.
module vm8_vedic4x4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);
    function automatic logic [3:0] v2(input logic [1:0] x, input logic [1:0] y);
        logic c;
        c  = (x[1] & y[0]) & (x[0] & y[1]);
        v2 = {(x[1] & y[1]) & c, (x[1] & y[1]) ^ c,
              (x[1] & y[0]) ^ (x[0] & y[1]), x[0] & y[0]};
    endfunction

    logic [3:0] m0, m1, m2, m3;

    assign m0  = v2(a_i[1:0], b_i[1:0]);
    assign m1  = v2(a_i[3:2], b_i[1:0]);
    assign m2  = v2(a_i[1:0], b_i[3:2]);
    assign m3  = v2(a_i[3:2], b_i[3:2]);
    assign p_o = {4'b0, m0} + {2'b0, m1, 2'b0}
               + {2'b0, m2, 2'b0} + {m3, 4'b0};
endmodule

module vm8_seq_ctrl #(
    parameter bit HOLD_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      state_q;
    logic [7:0]  ra_q, rb_q;
    logic [15:0] acc_q, acc_d, pp_sh;
    logic [1:0]  step_q;
    logic [15:0] p_q;
    logic        in_ready_q, out_valid_q;
    logic [3:0]  mul_a, mul_b;
    logic [7:0]  pp;
    logic        zero_op;

    assign mul_a = step_q[0] ? ra_q[7:4] : ra_q[3:0];
    assign mul_b = step_q[1] ? rb_q[7:4] : rb_q[3:0];

    vm8_vedic4x4 u_core (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (pp)
    );

    always_comb begin
        pp_sh = 16'd0;
        unique case (step_q)
            2'd0:    pp_sh = {8'd0, pp};
            2'd3:    pp_sh = {pp, 8'd0};
            default: pp_sh = {4'd0, pp, 4'd0};
        endcase
    end

    assign acc_d = acc_q + pp_sh;

`ifdef VM8_ZERO_SKIP_EN
    assign zero_op = (a == 8'd0) || (b == 8'd0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ra_q        <= 8'd0;
            rb_q        <= 8'd0;
            acc_q       <= 16'd0;
            step_q      <= 2'd0;
            p_q         <= 16'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        ra_q       <= a;
                        rb_q       <= b;
                        acc_q      <= 16'd0;
                        step_q     <= 2'd0;
                        in_ready_q <= 1'b0;
                        if (zero_op) begin
                            p_q         <= 16'd0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= MUL;
                        end
                    end
                end
                MUL: begin
                    acc_q  <= acc_d;
                    step_q <= step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        p_q         <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                        if (!HOLD_OUT) p_q <= 16'd0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign p         = p_q;
endmodule
